// File: rtl/join_sync_if.sv
// join_sync_if: two request/ack input channels and one combined output channel
interface join_sync_if #(parameter int W = 8);
    logic           r_i;
    logic           a_i;
    logic [W-1:0]   d_i;
    logic           r1_i;
    logic           a1_i;
    logic [W-1:0]   d1_i;
    logic           r_o;
    logic           a_o;
    logic [2*W-1:0] d_o;

    modport master (output r_i, d_i, r1_i, d1_i, a_o, input a_i, a1_i, r_o, d_o);
    modport slave  (input r_i, d_i, r1_i, d1_i, a_o, output a_i, a1_i, r_o, d_o);
endinterface

// File: rtl/join_sync.sv
// join_sync: clocked two-input 4-phase join with bundled data and synchronized handshakes
module join_sync #(
    parameter int W    = 8,
    parameter int SYNC = 2,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    join_sync_if.slave    bus,
    output logic [CW-1:0] count,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;

    state_t         state_q;
    logic [SYNC-1:0] rsync_q, r1sync_q, async_q;
    logic           rs, r1s, as_s;
    logic           rs_p_q, r1s_p_q, as_p_q;
    logic           r_o_q, ack_q, err_q, err_d;
    logic [2*W-1:0] d_o_q;
    logic [CW-1:0]  count_q;

    assign rs  = rsync_q[SYNC-1];
    assign r1s = r1sync_q[SYNC-1];
    assign as_s = async_q[SYNC-1];

    // Bring asynchronous handshake inputs into clk domain and keep last value for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsync_q  <= '0;
            r1sync_q <= '0;
            async_q  <= '0;
            rs_p_q   <= 1'b0;
            r1s_p_q  <= 1'b0;
            as_p_q   <= 1'b0;
        end else begin
            rsync_q  <= {rsync_q[SYNC-2:0], bus.r_i};
            r1sync_q <= {r1sync_q[SYNC-2:0], bus.r1_i};
            async_q  <= {async_q[SYNC-2:0], bus.a_o};
            rs_p_q   <= rs;
            r1s_p_q  <= r1s;
            as_p_q   <= as_s;
        end
    end

    // Sticky error: lone request withdrawn in IDLE, any request drop in REQ, or ack rising in IDLE
    always_comb begin
        err_d = err_q
              | (state_q == IDLE && ((rs_p_q && !rs && !r1s) || (r1s_p_q && !r1s && !rs)))
              | (state_q == REQ && ((rs_p_q && !rs) || (r1s_p_q && !r1s)))
              | (state_q == IDLE && as_s && !as_p_q);
    end

    // Join handshake FSM; all outputs registered, both acks always move together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_o_q   <= 1'b0;
            ack_q   <= 1'b0;
            d_o_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: if (rs && r1s) begin
                    d_o_q   <= {bus.d1_i, bus.d_i};
                    r_o_q   <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (as_s) begin
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: if (!rs && !r1s) begin
                    r_o_q   <= 1'b0;
                    state_q <= RTZ;
                end
                default: if (!as_s) begin
                    ack_q   <= 1'b0;
                    count_q <= count_q + 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.r_o  = r_o_q;
    assign bus.a_i  = ack_q;
    assign bus.a1_i = ack_q;
    assign bus.d_o  = d_o_q;
    assign count    = count_q;
    assign err      = err_q;
endmodule

// File: doc/join_sync.md
Name: join_sync

Overview:
- Clocked two-input join for the 4-phase (return-to-zero) request/acknowledge handshake with bundled data. It is the converging counterpart of the fork.
- It waits until both input channels present a request. It then issues one combined output request carrying both data words, and acknowledges both inputs only when the output acknowledges.
- It sits where a clocked consumer gathers two asynchronous producer streams into one channel. All handshake inputs are synchronized internally.

Parameters:
- W, 8, data width of each input channel; d_o is 2*W wide.
- SYNC, 2, synchronizer flop stages on r_i, r1_i and a_o; legal range 2..4.
- CW, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 => reset).
- r_i  input  1  request, channel 0 (asynchronous).
- a_i  output  1  acknowledge, channel 0.
- d_i  input  W  bundled data, channel 0; stable from r_i rise until a_i rise.
- r1_i  input  1  request, channel 1 (asynchronous).
- a1_i  output  1  acknowledge, channel 1.
- d1_i  input  W  bundled data, channel 1; same stability rule as d_i.
- r_o  output  1  combined output request.
- a_o  input  1  output acknowledge (asynchronous).
- d_o  output  2W  {d1_i, d_i} captured; stable while r_o=1.
- count  output  CW  completed transactions, modulo 2^CW.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; r_o=0, a_i=0, a1_i=0, d_o=0, count=0, err=0.
  - All synchronizer flops cleared.
  - Reset mid-handshake abandons the transaction; no partial outputs persist.
- Synchronizers: rs, r1s, as are the SYNC-stage synchronized versions of r_i, r1_i, a_o. The FSM sees only these.
- All outputs are registered; there are no combinational paths from input to output.
- FSM states and transitions:
  - IDLE: r_o=0, a_i=a1_i=0. When rs&r1s: capture d_o<={d1_i,d_i}, r_o<=1, go to REQ. If only one of them is high, wait in IDLE.
  - REQ: r_o=1. When as=1: a_i<=1, a1_i<=1, go to ACK.
  - ACK: r_o=1, acks=1. When rs=0 & r1s=0: r_o<=0, go to RTZ. If only one request is low, hold.
  - RTZ: r_o=0, acks=1. When as=0: a_i<=0, a1_i<=0, count<=count+1 (wraps 2^CW-1 -> 0), go to IDLE.
- Latency:
  - r_o rises SYNC+1 clk after the later of the two requests is stable high.
  - a_i/a1_i rise SYNC+1 clk after a_o rises.
  - r_o falls SYNC+1 clk after the later request falls.
  - Acks fall SYNC+1 clk after a_o falls.
- Both acknowledges always change in the same cycle.
- The two requests may arrive in any order, simultaneously, or arbitrarily skewed. The join completes only when both have arrived; there is no timeout.
- Protocol violations set err<=1. err stays set until reset, and the FSM continues normally after setting it. Violations are:
  - a request withdrawn in IDLE before its partner arrived (rs or r1s falls while state=IDLE and the other is 0);
  - a request falling while state=REQ;
  - a_o rising while state=IDLE.
- d_o changes only on the IDLE->REQ transition.

Test Plan:
- Reset, then r_i=1 with d_i=8'h3C, and 5 clk later r1_i=1 with d1_i=8'hA5 -> r_o rises 3 clk after r1_i (SYNC=2), d_o=16'hA53C. Then a_o=1 -> a_i and a1_i rise together 3 clk later.
- Full cycle: after the acks, drop r_i, then drop r1_i 4 clk later -> r_o falls 3 clk after r1_i drops. Then a_o=0 -> acks fall 3 clk later, count=1, err=0.
- Simultaneous requests with back-to-back transactions, 256 iterations at CW=8 -> count wraps to 0. Each d_o matches its captured pair. r_o never rises before both acks have fallen.
- r_i=1 then r_i=0 in IDLE with r1_i=0 -> err=1 after sync delay. A subsequent valid transaction still completes and count increments.
- Assert rst=0 while in ACK -> r_o, a_i, a1_i, count, err all 0 immediately (asynchronously). After release with the requests held low, the FSM stays in IDLE.
- a_o pulsed high in IDLE -> err=1 and r_o stays 0.
